// File: rtl/rocketcpu_timer.sv
// Wishbone-slave 32-bit timer: prescaled counter, compare match, periodic or one-shot,
// emitting a one-cycle o_irq pulse per match toward the interrupt controller.
module rocketcpu_timer #(
    parameter logic [31:0] BASE_ADR = 32'h0A00_0000,
    parameter int          PRESC_W  = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam logic [31:0] ADR_CTRL     = BASE_ADR;
    localparam logic [31:0] ADR_PRESCALE = BASE_ADR + 32'h4;
    localparam logic [31:0] ADR_COMPARE  = BASE_ADR + 32'h8;
    localparam logic [31:0] ADR_COUNT    = BASE_ADR + 32'hC;
    localparam logic [31:0] ADR_STATUS   = BASE_ADR + 32'h10;
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic               en;
    logic               periodic;
    logic               irq_en;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic [31:0]        compare;
    logic [31:0]        count;
    logic               match_flag;

    // Handshake: a transfer happens on every edge where i_wb_cyc is high and o_wb_ack is low;
    // ack rises for exactly one cycle, the write commits on that edge, and o_wb_rdt carries
    // the pre-edge register value. Holding cyc high therefore acks every other cycle.
    logic strobe;
    logic wr;
    logic wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;

    assign strobe      = i_wb_cyc & ~o_wb_ack;
    assign wr          = strobe & i_wb_we;
    assign wr_ctrl     = wr & (i_wb_adr == ADR_CTRL);
    assign wr_prescale = wr & (i_wb_adr == ADR_PRESCALE);
    assign wr_compare  = wr & (i_wb_adr == ADR_COMPARE);
    assign wr_count    = wr & (i_wb_adr == ADR_COUNT);
    assign wr_status   = wr & (i_wb_adr == ADR_STATUS);

    logic tick;
    logic match;

    assign tick  = en & (presc_cnt == prescale);
    assign match = tick & (count == compare);

    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        if (i_wb_adr == ADR_CTRL)          rdata = {29'd0, irq_en, periodic, en};
        else if (i_wb_adr == ADR_PRESCALE) rdata = 32'(prescale);
        else if (i_wb_adr == ADR_COMPARE)  rdata = compare;
        else if (i_wb_adr == ADR_COUNT)    rdata = count;
        else if (i_wb_adr == ADR_STATUS)   rdata = {31'd0, match_flag};
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= 32'd0;
        end else begin
            o_wb_ack <= strobe;
            if (strobe) o_wb_rdt <= rdata;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            compare  <= 32'hFFFF_FFFF;
        end else begin
            // A software CTRL write overrides the one-shot auto-disable on the same edge.
            if (wr_ctrl) begin
                en       <= i_wb_dat[0];
                periodic <= i_wb_dat[1];
                irq_en   <= i_wb_dat[2];
            end else if (match && !periodic) begin
                en <= 1'b0;
            end
            if (wr_prescale) prescale <= i_wb_dat[PRESC_W-1:0];
            if (wr_compare)  compare  <= i_wb_dat;
        end
    end

    // Equality-only reload lets a counter above a freshly lowered PRESCALE wrap naturally.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            presc_cnt <= '0;
        end else if (wr_count) begin
            presc_cnt <= '0;
        end else if (en) begin
            if (presc_cnt == prescale) presc_cnt <= '0;
            else                       presc_cnt <= presc_cnt + PRESC_ONE;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            count <= 32'd0;
        end else if (wr_count) begin
            count <= i_wb_dat;
        end else if (tick) begin
            if (match) count <= 32'd0;
            else       count <= count + 32'd1;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            match_flag <= 1'b0;
            o_irq      <= 1'b0;
        end else begin
            if (match)                      match_flag <= 1'b1;
            else if (wr_status && i_wb_dat[0]) match_flag <= 1'b0;
            o_irq <= match & irq_en;
        end
    end

endmodule

// File: tb/tb_rocketcpu_timer.sv
// Directed bench for rocketcpu_timer: reads and irq pulses are checked by a monitor
// against expected queues filled at stimulus time.
module tb_rocketcpu_timer;

    localparam logic [31:0] BASE       = 32'h0A00_0000;
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_PRESC  = 32'h04;
    localparam logic [31:0] OFF_CMP    = 32'h08;
    localparam logic [31:0] OFF_CNT    = 32'h0C;
    localparam logic [31:0] OFF_STAT   = 32'h10;
    localparam logic [31:0] OFF_NONE   = 32'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat = 32'd0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    rocketcpu_timer #(.BASE_ADR(BASE), .PRESC_W(16)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (adr),
        .i_wb_dat   (dat),
        .i_wb_we    (we),
        .i_wb_cyc   (cyc),
        .o_wb_rdt   (rdt),
        .o_wb_ack   (ack),
        .o_irq      (irq)
    );

    // Clock and edge counter
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int tests_run = 0;
    int tests_failed = 0;
    int last_edge = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          irq_exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (ack && !we) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected_ack", {31'd0, ack}, 32'd0);
            end else begin
                chk(name_q.pop_front(), rdt, exp_q.pop_front());
            end
        end
        if (irq) begin
            if (irq_exp_q.size() == 0) chk("irq_unexpected", {31'd0, irq}, 32'd0);
            else                       chk("irq_cycle", cyc_n, irq_exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic wb(input logic [31:0] off, input logic [31:0] d, input logic w);
        int n;
        @(negedge clk);
        adr = BASE + off;
        dat = d;
        we  = w;
        cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 4);
        if (!ack) chk("ack_timeout", {31'd0, ack}, 32'd1);
        last_edge = cyc_n;
        cyc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        wb(off, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] expv, input string name);
        exp_q.push_back(expv);
        name_q.push_back(name);
        wb(off, 32'd0, 1'b0);
    endtask

    // Wait so that the next access commits on edge x.
    task automatic goto_edge(input int x);
        if (cyc_n > x - 1) chk("schedule", cyc_n, x - 1);
        while (cyc_n < x - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_irq_drained(input string name);
        chk(name, irq_exp_q.size(), 32'd0);
        irq_exp_q.delete();
    endtask

    int e;
    logic [5:0] ack_pat;

    initial begin
        // Reset state
        #2;
        chk("rst_rdt", rdt, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(OFF_CMP,   32'hFFFF_FFFF, "rst_compare");
        rd(OFF_CTRL,  32'd0, "rst_ctrl");
        rd(OFF_CNT,   32'd0, "rst_count");
        rd(OFF_STAT,  32'd0, "rst_status");
        rd(OFF_PRESC, 32'd0, "rst_prescale");

        // Periodic: tick every 4 cycles, match every 5 ticks
        wr(OFF_PRESC, 32'd3);
        wr(OFF_CMP, 32'd4);
        rd(OFF_PRESC, 32'd3, "per_prescale_rb");
        e = cyc_n + 1;
        irq_exp_q.push_back(e + 20);
        irq_exp_q.push_back(e + 40);
        irq_exp_q.push_back(e + 60);
        wr(OFF_CTRL, 32'd7);
        chk("per_edge", last_edge, e);
        goto_edge(e + 27); rd(OFF_CNT, 32'd1, "per_count_1");
        goto_edge(e + 35); rd(OFF_CNT, 32'd3, "per_count_3");
        goto_edge(e + 38); rd(OFF_CNT, 32'd4, "per_count_4");
        goto_edge(e + 41); rd(OFF_STAT, 32'd1, "per_status_set");
        goto_edge(e + 43); wr(OFF_STAT, 32'd1);
        goto_edge(e + 45); rd(OFF_STAT, 32'd0, "per_status_clr");
        goto_edge(e + 62); wr(OFF_CTRL, 32'd0);
        chk_irq_drained("per_irq_missing");
        wr(OFF_CNT, 32'd0);
        wr(OFF_STAT, 32'd1);

        // One-shot: PRESCALE=0, COMPARE=2
        wr(OFF_PRESC, 32'd0);
        wr(OFF_CMP, 32'd2);
        e = cyc_n + 1;
        irq_exp_q.push_back(e + 3);
        wr(OFF_CTRL, 32'd5);
        goto_edge(e + 5);
        rd(OFF_CTRL, 32'd4, "os_ctrl");
        rd(OFF_CNT,  32'd0, "os_count");
        rd(OFF_STAT, 32'd1, "os_status");
        wr(OFF_STAT, 32'd1);
        chk_irq_drained("os_irq_missing");

        // IRQ gating: match sets STATUS but no pulse
        wr(OFF_CMP, 32'd1);
        e = cyc_n + 1;
        wr(OFF_CTRL, 32'd3);
        goto_edge(e + 4);
        rd(OFF_STAT, 32'd1, "gate_status");
        wr(OFF_CTRL, 32'd0);
        wr(OFF_CNT, 32'd0);
        wr(OFF_STAT, 32'd1);

        // Collision: COUNT write on the match edge
        wr(OFF_CMP, 32'd3);
        e = cyc_n + 1;
        wr(OFF_CTRL, 32'd5);
        irq_exp_q.push_back(e + 4);
        goto_edge(e + 4);
        wr(OFF_CNT, 32'd7);
        rd(OFF_CNT,  32'd7, "col_count");
        rd(OFF_STAT, 32'd1, "col_status");
        rd(OFF_CTRL, 32'd4, "col_ctrl");
        chk_irq_drained("col_irq_missing");
        wr(OFF_STAT, 32'd1);

        // Wrap: COUNT above COMPARE runs through 0 first
        wr(OFF_CNT, 32'hFFFF_FFFE);
        wr(OFF_CMP, 32'd1);
        e = cyc_n + 1;
        irq_exp_q.push_back(e + 4);
        wr(OFF_CTRL, 32'd5);
        goto_edge(e + 6);
        rd(OFF_CNT,  32'd0, "wrap_count");
        rd(OFF_CTRL, 32'd4, "wrap_ctrl");
        chk_irq_drained("wrap_irq_missing");
        wr(OFF_STAT, 32'd1);

        // COMPARE=0: every tick matches, back-to-back pulses
        wr(OFF_CMP, 32'd0);
        e = cyc_n + 1;
        for (int i = 1; i <= 4; i++) irq_exp_q.push_back(e + i);
        wr(OFF_CTRL, 32'd7);
        goto_edge(e + 4);
        wr(OFF_CTRL, 32'd0);
        chk_irq_drained("cmp0_irq_missing");
        wr(OFF_STAT, 32'd1);

        // Bus protocol: cyc held for 6 cycles
        ack_pat = 6'b101010;
        @(negedge clk);
        adr = BASE + OFF_CTRL;
        we  = 1'b0;
        cyc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'd0);
            name_q.push_back("hold_rd");
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("ack_pattern", {31'd0, ack}, {31'd0, ack_pat[i]});
        end
        cyc = 1'b0;
        @(posedge clk);
        #1;

        // Unmapped offset
        wr(OFF_CMP, 32'd5);
        rd(OFF_NONE, 32'd0, "unmapped_rd");
        wr(OFF_NONE, 32'hFFFF_FFFF);
        rd(OFF_CTRL,  32'd0, "unmapped_ctrl");
        rd(OFF_PRESC, 32'd0, "unmapped_prescale");
        rd(OFF_CMP,   32'd5, "unmapped_compare");
        rd(OFF_CNT,   32'd0, "unmapped_count");
        rd(OFF_STAT,  32'd0, "unmapped_status");

        // Reset mid-operation with ack and irq both high
        wr(OFF_CMP, 32'd0);
        e = cyc_n + 1;
        for (int i = 1; i <= 3; i++) irq_exp_q.push_back(e + i);
        wr(OFF_CTRL, 32'd7);
        goto_edge(e + 3);
        @(negedge clk);
        adr = BASE + OFF_CTRL;
        we  = 1'b0;
        cyc = 1'b1;
        exp_q.push_back(32'd7);
        name_q.push_back("mid_rd_ctrl");
        @(posedge clk);
        #3;
        chk("mid_pre_ack", {31'd0, ack}, 32'd1);
        chk("mid_pre_irq", {31'd0, irq}, 32'd1);
        cyc = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdt", rdt, 32'd0);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_irq_drained("mid_irq_missing");
        rd(OFF_CMP,  32'hFFFF_FFFF, "mid_compare");
        rd(OFF_CTRL, 32'd0, "mid_ctrl");
        rd(OFF_CNT,  32'd0, "mid_count");
        rd(OFF_STAT, 32'd0, "mid_status");

        // Final report
        repeat (3) @(posedge clk);
        #2;
        chk("rd_queue_left", exp_q.size(), 32'd0);
        chk("irq_queue_left", irq_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
